alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
- Command sequencer that sits between the UART receiver/transmitter pair and the combinational ALU.
- It collects three received bytes in order: operand A, operand B, then opcode. It holds them stable on the ALU inputs and captures the ALU result.
- It then hands the result byte to the UART transmitter and waits for its completion.
- It is the initiator/consumer side of the ALU operand/result interface.

Parameters:
- p_dataLength, 8, operand/result width; must equal p_byteLength in this revision.
- p_byteLength, 8, UART data byte width.
- p_operatorsInputSize, 4, opcode width driven to the ALU; taken from the low bits of the opcode byte.
- p_timeoutCycles, 50000000, inter-byte timeout in clock cycles; used only with the optional feature.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_rxData  in  p_byteLength  received byte; valid when i_rxDone=1.
- i_rxDone  in  1  one-cycle pulse per received byte.
- i_ALUResult  in  p_dataLength  combinational ALU result.
- i_txDone  in  1  one-cycle pulse when the transmitter finishes a byte.
- o_A  out  p_dataLength  registered operand A to the ALU.
- o_B  out  p_dataLength  registered operand B to the ALU.
- o_ALUBitsControl  out  p_operatorsInputSize  registered opcode to the ALU.
- o_txData  out  p_byteLength  registered result byte to the transmitter.
- o_txStart  out  1  one-cycle start pulse to the transmitter.
- o_busy  out  1  high in any state other than WAIT_A.

Behaviour:
- Reset values (synchronous, i_reset=1 at a rising edge):
  - state = WAIT_A.
  - o_A, o_B, o_ALUBitsControl, o_txData all zero.
  - o_txStart = 0, o_busy = 0.
  - Reset mid-operation aborts the sequence; no partial transmission is started.
- State machine (binary encoded, 6 states):
  - WAIT_A: on i_rxDone, o_A <= i_rxData, go to WAIT_B.
  - WAIT_B: on i_rxDone, o_B <= i_rxData, go to WAIT_OP.
  - WAIT_OP: on i_rxDone, o_ALUBitsControl <= i_rxData[p_operatorsInputSize-1:0], go to CAPTURE. The upper opcode bits are discarded.
  - CAPTURE: exactly one cycle. Inputs are now stable, so o_txData <= i_ALUResult. Go to SEND.
  - SEND: exactly one cycle. o_txStart = 1. Go to WAIT_TX.
  - WAIT_TX: on i_txDone, go to WAIT_A. Otherwise hold.
- Latency:
  - Opcode i_rxDone edge to o_txStart high: 2 cycles (CAPTURE, then SEND).
  - i_txDone to ready for a new A byte: 1 cycle.
- Output stability:
  - o_A, o_B and o_ALUBitsControl hold their values until overwritten by the next command.
  - The ALU output therefore stays valid after the transaction.
- Byte dropping:
  - i_rxDone in CAPTURE, SEND or WAIT_TX is ignored; the byte is dropped and no state changes.
  - This includes i_rxDone coincident with i_txDone in WAIT_TX: return to WAIT_A, byte dropped.
- Handshake robustness:
  - i_txDone outside WAIT_TX is ignored.
  - o_txStart is never asserted for more than one cycle per command.
- Opcode handling: an undefined opcode is passed through unchanged. The ALU returns 0 for it and 0x00 is transmitted.
- Arithmetic: none inside this block; all widths pass straight through.

Optional Feature:
- Macro: ALU_UART_INTERFACE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(p_timeoutCycles+1) runs in WAIT_B and WAIT_OP.
  - It is cleared on every i_rxDone and on every state entry.
  - When it reaches p_timeoutCycles-1 without i_rxDone, the state returns to WAIT_A. Registered operands are not cleared.
  - i_rxDone in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- Undefined: no counter exists; WAIT_B and WAIT_OP wait indefinitely.

Decomposition:
- Shared include/package alu_pkg:
  - state encodings.
  - ALU opcode constants: ADD 4'b0001, SUB 4'b0010, AND 4'b0011, OR 4'b0101, XOR 4'b0111, SRA 4'b1000, SRL 4'b1100, NOR 4'b1110.
  - The ALU and the bench reuse the same constants.
- One sub-module is natural: alu_uart_timeout. It is the clearable timeout counter, instantiated only under the macro.
- The ALU is not instantiated inside this block; the top level connects the two.

Test Plan:
- Reset then rx A=0x05, B=0x03, op=0x01 (ALU connected) -> o_txData=0x08, o_txStart single pulse 2 cycles after the op byte; after i_txDone, o_busy=0.
- Rx A=0x80, B=0x02, op=0x08 (SRA) -> transmit 0xE0. Repeat with op=0x0C (SRL) -> 0x20. Rx op=0xF2 -> o_ALUBitsControl=0x2 (SUB), transmit 0x7E.
- Rx byte pulsed during WAIT_TX, including the same cycle as i_txDone -> byte dropped, state WAIT_A, next three bytes form a correct new command.
- i_reset asserted in WAIT_OP after A and B are loaded -> all outputs zero next cycle, no o_txStart. A fresh A=0x01, B=0x01, op=0x0E -> transmit 0xFE.
- Op=0x09 (undefined) -> transmit 0x00, exactly one o_txStart.
- With ALU_UART_INTERFACE_TIMEOUT_EN and p_timeoutCycles=16: A only, then silence 16 cycles -> o_busy falls. An A byte arriving on cycle 15 after B -> accepted as opcode, no timeout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: FSM state encodings and ALU opcodes.
// The ALU and the bench reuse the opcode constants so both sides agree on the encoding.
package alu_pkg;

    // Sequencer states, binary encoded
    localparam logic [2:0] StWaitA   = 3'd0;
    localparam logic [2:0] StWaitB   = 3'd1;
    localparam logic [2:0] StWaitOp  = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StSend    = 3'd4;
    localparam logic [2:0] StWaitTx  = 3'd5;

    // ALU opcodes; any other value makes the ALU return zero
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0011;
    localparam logic [3:0] OpOr  = 4'b0101;
    localparam logic [3:0] OpXor = 4'b0111;
    localparam logic [3:0] OpSra = 4'b1000;
    localparam logic [3:0] OpSrl = 4'b1100;
    localparam logic [3:0] OpNor = 4'b1110;

endpackage

// File: rtl/alu_uart_timeout.sv
// Clearable inter-byte timeout counter; only instantiated when ALU_UART_INTERFACE_TIMEOUT_EN
// is defined. expired is high while running and the count sits at p_timeoutCycles-1.
module alu_uart_timeout #(
    parameter int unsigned p_timeoutCycles = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CntW = $clog2(p_timeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(p_timeoutCycles - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || !run) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && (count_q == CntLast);

endmodule

// File: rtl/alu_uart_interface.sv
// Sequencer between a UART rx/tx pair and a combinational ALU: collects A, B, opcode bytes,
// captures the ALU result and transmits it. Optional inter-byte timeout: ALU_UART_INTERFACE_TIMEOUT_EN.
module alu_uart_interface
    import alu_pkg::*;
#(
    parameter int unsigned p_dataLength         = 8,
    parameter int unsigned p_byteLength         = 8,
    parameter int unsigned p_operatorsInputSize = 4,
    parameter int unsigned p_timeoutCycles      = 50000000
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [p_byteLength-1:0]         i_rxData,
    input  logic                            i_rxDone,
    input  logic [p_dataLength-1:0]         i_ALUResult,
    input  logic                            i_txDone,
    output logic [p_dataLength-1:0]         o_A,
    output logic [p_dataLength-1:0]         o_B,
    output logic [p_operatorsInputSize-1:0] o_ALUBitsControl,
    output logic [p_byteLength-1:0]         o_txData,
    output logic                            o_txStart,
    output logic                            o_busy
);

    if (p_dataLength != p_byteLength) begin : g_width_check
        $error("alu_uart_interface: p_dataLength must equal p_byteLength");
    end
    if (p_timeoutCycles < 2) begin : g_timeout_check
        $error("alu_uart_interface: p_timeoutCycles must be at least 2");
    end

    logic [2:0]                      state_q, state_d;
    logic [p_dataLength-1:0]         a_q, a_d;
    logic [p_dataLength-1:0]         b_q, b_d;
    logic [p_operatorsInputSize-1:0] op_q, op_d;
    logic [p_byteLength-1:0]         tx_data_q, tx_data_d;
    logic                            timeout_expired;

`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
    logic timeout_run;
    logic timeout_clear;

    assign timeout_run   = (state_q == StWaitB) || (state_q == StWaitOp);
    // Clearing on every accepted byte and on expiry also covers every state entry.
    assign timeout_clear = i_rxDone || timeout_expired;

    alu_uart_timeout #(
        .p_timeoutCycles (p_timeoutCycles)
    ) u_timeout (
        .clk     (i_clk),
        .reset   (i_reset),
        .run     (timeout_run),
        .clear   (timeout_clear),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        case (state_q)
            StWaitA: begin
                if (i_rxDone) begin
                    a_d     = i_rxData;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (i_rxDone) begin
                    b_d     = i_rxData;
                    state_d = StWaitOp;
                end else if (timeout_expired) begin
                    state_d = StWaitA;
                end
            end
            StWaitOp: begin
                if (i_rxDone) begin
                    op_d    = i_rxData[p_operatorsInputSize-1:0];
                    state_d = StCapture;
                end else if (timeout_expired) begin
                    state_d = StWaitA;
                end
            end
            StCapture: begin
                // Operands have been stable for a full cycle, so the ALU output is settled.
                tx_data_d = i_ALUResult;
                state_d   = StSend;
            end
            StSend: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (i_txDone) begin
                    state_d = StWaitA;
                end
            end
            default: begin
                state_d = StWaitA;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StWaitA;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign o_A              = a_q;
    assign o_B              = b_q;
    assign o_ALUBitsControl = op_q;
    assign o_txData         = tx_data_q;
    assign o_txStart        = (state_q == StSend);
    assign o_busy           = (state_q != StWaitA);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface with a behavioural ALU; the timeout scenario
// runs only when ALU_UART_INTERFACE_TIMEOUT_EN is defined.
module tb_alu_uart_interface;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] o_a;
    logic [7:0] o_b;
    logic [3:0] o_ctrl;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_uart_interface #(
        .p_dataLength         (8),
        .p_byteLength         (8),
        .p_operatorsInputSize (4),
        .p_timeoutCycles      (16)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_rxData         (rx_data),
        .i_rxDone         (rx_done),
        .i_ALUResult      (alu_result),
        .i_txDone         (tx_done),
        .o_A              (o_a),
        .o_B              (o_b),
        .o_ALUBitsControl (o_ctrl),
        .o_txData         (tx_data),
        .o_txStart        (tx_start),
        .o_busy           (busy)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpSra:   return 8'($signed(a) >>> b);
            OpSrl:   return a >> b;
            OpNor:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(o_a, o_b, o_ctrl);

    // Scoreboard: every start pulse must be one cycle wide and carry the oldest expected byte.
    initial begin
        logic       prev_start;
        logic [7:0] exp;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                n_starts++;
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL txstart_width: o_txStart high %0d consecutive cycles, required 1", 2);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: o_txStart with txData=%h, no command pending",
                             tx_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (tx_data !== exp) begin
                        errors++;
                        $display("FAIL tx_data: got %h, required %h", tx_data, exp);
                    end
                end
            end
            prev_start = (tx_start === 1'b1);
        end
    end

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'hxx;
    endtask

    task automatic tx_complete();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n0;
        bit seen;
        n0 = n_starts;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (n_starts != n0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_start_timeout: no o_txStart within 8 cycles, required one", name);
        end
    endtask

    task automatic send_cmd(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
        exp_q.push_back(exp);
        rx_byte(a);
        rx_byte(b);
        rx_byte(op);
        wait_start(name);
    endtask

    task automatic run_cmd(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
        send_cmd(name, a, b, op, exp);
        tx_complete();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_tx: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks += 6;
        if (o_a !== 8'h00) begin errors++; $display("FAIL reset_a: got %h, required 00", o_a); end
        if (o_b !== 8'h00) begin errors++; $display("FAIL reset_b: got %h, required 00", o_b); end
        if (o_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", o_ctrl); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h, required 00", tx_data); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_txstart: got %b, required 0", tx_start); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_add_latency();
        exp_q.push_back(8'h08);
        rx_byte(8'h05);
        rx_byte(8'h03);
        rx_byte(8'h01);
        // Now one cycle after the opcode edge: CAPTURE
        checks += 3;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL add_early_start: got %b, required 0", tx_start); end
        @(negedge clk);
        if (tx_start !== 1'b1) begin errors++; $display("FAIL add_start_latency: got %b, required 1", tx_start); end
        @(negedge clk);
        if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_waittx: got %b, required 1", busy); end
        tx_complete();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_after_tx: got %b, required 0", busy); end
    endtask

    task automatic test_shifts();
        run_cmd("sra", 8'h80, 8'h02, 8'h08, 8'hE0);
        run_cmd("srl", 8'h80, 8'h02, 8'h0C, 8'h20);
        run_cmd("sub_hi", 8'h80, 8'h02, 8'hF2, 8'h7E);
        checks++;
        if (o_ctrl !== OpSub) begin
            errors++;
            $display("FAIL opcode_trunc: got %h, required %h", o_ctrl, OpSub);
        end
    endtask

    task automatic test_drop();
        send_cmd("drop", 8'h10, 8'h20, 8'h01, 8'h30);
        rx_byte(8'h99);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b, required 1", busy); end
        if (o_a !== 8'h10) begin errors++; $display("FAIL drop_a_kept: got %h, required 10", o_a); end
        @(negedge clk);
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_coincident_busy: got %b, required 0", busy); end
        if (o_a !== 8'h10) begin errors++; $display("FAIL drop_coincident_a: got %h, required 10", o_a); end
        run_cmd("after_drop", 8'h07, 8'h03, 8'h07, 8'h04);
        checks++;
        if (o_a !== 8'h07) begin errors++; $display("FAIL after_drop_a: got %h, required 07", o_a); end
    endtask

    task automatic test_handshake();
        int n0;
        n0 = n_starts;
        tx_complete();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stray_txdone_idle: got busy %b, required 0", busy); end
        exp_q.push_back(8'h01);
        rx_byte(8'h0F);
        tx_complete();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stray_txdone_waitb: got busy %b, required 1", busy); end
        rx_byte(8'h01);
        rx_byte(8'h03);
        wait_start("hs");
        repeat (3) @(negedge clk);
        tx_complete();
        checks++;
        if (n_starts !== n0 + 1) begin
            errors++;
            $display("FAIL hs_start_count: got %0d, required %0d", n_starts - n0, 1);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = n_starts;
        rx_byte(8'h11);
        rx_byte(8'h22);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 5;
        if (o_a !== 8'h00) begin errors++; $display("FAIL midreset_a: got %h, required 00", o_a); end
        if (o_b !== 8'h00) begin errors++; $display("FAIL midreset_b: got %h, required 00", o_b); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL midreset_txdata: got %h, required 00", tx_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL midreset_txstart: got %b, required 0", tx_start); end
        repeat (4) @(negedge clk);
        checks++;
        if (n_starts !== n0) begin errors++; $display("FAIL midreset_no_start: got %0d starts, required 0", n_starts - n0); end
        run_cmd("nor", 8'h01, 8'h01, 8'h0E, 8'hFE);
    endtask

    task automatic test_undefined();
        int n0;
        n0 = n_starts;
        run_cmd("undef", 8'h33, 8'h44, 8'h09, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (n_starts !== n0 + 1) begin
            errors++;
            $display("FAIL undef_start_count: got %0d, required 1", n_starts - n0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[8];
        logic [7:0] a, b, op;
        ops = '{OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSra, OpSrl, OpNor};
        for (int i = 0; i < 8; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom_range(0, 7));
            op = {4'($urandom), ops[i]};
            run_cmd("b2b", a, b, op, alu_model(a, b, op[3:0]));
        end
    endtask

`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
    task automatic test_timeout();
        rx_byte(8'h05);
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got busy %b, required 1", busy); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_expire: got busy %b, required 0", busy); end
        if (o_a !== 8'h05) begin errors++; $display("FAIL timeout_a_kept: got %h, required 05", o_a); end
        exp_q.push_back(8'h08);
        rx_byte(8'h05);
        rx_byte(8'h03);
        repeat (14) @(negedge clk);
        rx_byte(8'h01);
        wait_start("timeout_edge");
        tx_complete();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_edge_busy: got %b, required 0", busy); end
    endtask
`endif

    initial begin
        reset   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_add_latency();
        test_shifts();
        test_drop();
        test_handshake();
        test_reset_mid();
        test_undefined();
        test_back_to_back();
`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
